// File: rtl/pc_unit.sv
// Program counter and next-PC selection for the single-cycle core.
// Covers branches, absolute and register jumps, a return-address stack, and exception entry/return.
module pc_unit #(
   parameter int unsigned     XLEN       = 32,
   parameter logic [XLEN-1:0] RESET_PC   = '0,
   parameter logic [31:0]     EXC_VECTOR = 32'h0000_0180,
   parameter int unsigned     RAS_DEPTH  = 4
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            pc_wr,
   input  logic            branch,
   input  logic            jump,
   input  logic            link,
   input  logic            jump_reg,
   input  logic            ret,
   input  logic            exc,
   input  logic            eret,
   input  logic [XLEN-1:0] imm32,
   input  logic [25:0]     imm26,
   input  logic [XLEN-1:0] rs_val,
   output logic [XLEN-1:0] pc,
   output logic [XLEN-1:0] npc,
   output logic [XLEN-1:0] epc,
   output logic            ras_empty,
   output logic            ras_full
);

   localparam int unsigned     PW         = (RAS_DEPTH > 2) ? $clog2(RAS_DEPTH) : 1;
   localparam logic [XLEN-1:0] EXC_PC     = XLEN'(EXC_VECTOR);
   localparam logic [XLEN-1:0] INSN_BYTES = XLEN'(4);
   localparam logic [XLEN-1:0] WORD_MASK  = ~XLEN'(3);
   localparam logic [PW:0]     CNT_FULL   = (PW+1)'(RAS_DEPTH);
   localparam logic [PW:0]     CNT_ONE    = (PW+1)'(1);
   localparam logic [PW-1:0]   PTR_ONE    = PW'(1);

   typedef enum logic [2:0] {
      SRC_EXC,
      SRC_ERET,
      SRC_BRANCH,
      SRC_RAS,
      SRC_REG,
      SRC_JUMP,
      SRC_SEQ
   } npc_src_t;

   logic [XLEN-1:0] pc_q;
   logic [XLEN-1:0] epc_q;
   logic [XLEN-1:0] pc_plus4;
   logic [XLEN-1:0] ras_top;
   logic [XLEN-1:0] ras_mem [RAS_DEPTH];
   logic [PW-1:0]   ras_ptr;
   logic [PW:0]     ras_cnt;
   npc_src_t        src;
   logic            advance;
   logic            do_push;
   logic            do_pop;

   assign pc_plus4  = pc_q + INSN_BYTES;
   // Write pointer addresses the next free slot; the top entry sits just below it.
   assign ras_top   = ras_mem[ras_ptr - PTR_ONE];
   assign ras_empty = (ras_cnt == '0);
   assign ras_full  = (ras_cnt == CNT_FULL);

   always_comb begin
      src = SRC_SEQ;
      if (exc)                             src = SRC_EXC;
      else if (eret)                       src = SRC_ERET;
      else if (branch)                     src = SRC_BRANCH;
      else if (jump_reg && ret && !ras_empty) src = SRC_RAS;
      else if (jump_reg)                   src = SRC_REG;
      else if (jump)                       src = SRC_JUMP;
   end

   always_comb begin
      npc = pc_plus4;
      case (src)
         SRC_EXC:    npc = EXC_PC;
         SRC_ERET:   npc = epc_q;
         SRC_BRANCH: npc = pc_plus4 + imm32;
         SRC_RAS:    npc = ras_top;
         SRC_REG:    npc = rs_val & WORD_MASK;
         SRC_JUMP:   npc = {pc_q[XLEN-1:28], imm26, 2'b00};
         default:    npc = pc_plus4;
      endcase
   end

   // Stack side effects belong only to the winning source of an advancing cycle.
   assign advance = pc_wr && !exc;
   assign do_push = advance && (src == SRC_JUMP) && link;
   assign do_pop  = advance && (src == SRC_RAS);

   always_ff @(posedge clk) begin
      if (reset) begin
         pc_q    <= RESET_PC;
         epc_q   <= '0;
         ras_ptr <= '0;
         ras_cnt <= '0;
      end else begin
         if (exc) begin
            pc_q  <= EXC_PC;
            epc_q <= pc_q;
         end else if (pc_wr) begin
            pc_q <= npc;
         end

         if (do_push) begin
            ras_ptr <= ras_ptr + PTR_ONE;
            if (ras_cnt != CNT_FULL) ras_cnt <= ras_cnt + CNT_ONE;
         end else if (do_pop) begin
            ras_ptr <= ras_ptr - PTR_ONE;
            ras_cnt <= ras_cnt - CNT_ONE;
         end
      end
   end

   // A push into a full stack lands on the oldest entry, which is exactly the slot the pointer names.
   always_ff @(posedge clk) begin
      if (do_push) ras_mem[ras_ptr] <= pc_plus4;
   end

   assign pc  = pc_q;
   assign epc = epc_q;

endmodule

// File: doc/pc_unit.md
Name: pc_unit

Overview:
- Parametrised program-counter / next-PC block for the single-cycle core.
- Successor to the current fixed-width PC/NPC logic. Adds:
  - register-indirect jumps
  - a return-address stack (RAS)
  - exception entry and return with a saved EPC
  - stall via write-enable
- Sits between the control unit (branch/jump decode) and instruction memory. Drives the fetch address every cycle.

Parameters:
- XLEN, 32: PC and data width. Must be >= 32.
- RESET_PC, 0: PC value after reset.
- EXC_VECTOR, 32'h0000_0180: exception handler entry address, zero-extended to XLEN.
- RAS_DEPTH, 4: return-address stack entries. Power of two, >= 2.

Ports:
- clk  in  1  clock, rising-edge active
- reset  in  1  synchronous, active-high
- pc_wr  in  1  1 = PC advances this cycle; 0 = stall (hold)
- branch  in  1  conditional branch taken
- jump  in  1  absolute jump using imm26
- link  in  1  with jump: push return address onto RAS
- jump_reg  in  1  indirect jump to rs_val
- ret  in  1  with jump_reg: target is RAS top (pop)
- exc  in  1  exception request
- eret  in  1  return from exception
- imm32  in  XLEN  branch byte offset, already sign-extended and shifted
- imm26  in  26  jump word index
- rs_val  in  XLEN  register operand for indirect jump
- pc  out  XLEN  current fetch address (registered)
- npc  out  XLEN  next PC (combinational)
- epc  out  XLEN  saved exception PC (registered)
- ras_empty  out  1  RAS holds no entries
- ras_full  out  1  RAS holds RAS_DEPTH entries

Behaviour:
- Reset, at a rising edge with reset=1:
  - pc=RESET_PC, epc=0, RAS count=0, RAS write pointer=0.
  - ras_empty=1, ras_full=0.
  - reset dominates all other inputs, including mid-stall or mid-exception.
- npc selection, combinational. Highest priority first:
  1. exc -> EXC_VECTOR
  2. eret -> epc
  3. branch -> pc+4+imm32
  4. jump_reg & ret & !ras_empty -> RAS top
  5. jump_reg -> rs_val with bits [1:0] forced to 0. This also covers ret when the RAS is empty.
  6. jump -> {pc[XLEN-1:28], imm26, 2'b00}
  7. otherwise -> pc+4
- Arithmetic is modulo 2^XLEN. pc+4 at the all-ones-minus-3 address wraps to 0.
- Register update at a rising edge, reset=0:
  - exc=1: pc<=EXC_VECTOR and epc<=pc, regardless of pc_wr. An exception overrides a stall.
  - else pc_wr=1: pc<=npc. epc holds.
  - else: pc holds, epc holds, RAS unchanged.
- Side effects apply only to the selected source (the winning priority), and only when pc_wr=1 and exc=0:
  - Push: on source 6 with link=1, write pc+4 at the write pointer and increment the pointer modulo RAS_DEPTH.
    - Count increments, saturating at RAS_DEPTH.
    - Push when full overwrites the oldest entry. ras_full stays 1.
  - Pop: on source 4, decrement the pointer modulo RAS_DEPTH and decrement the count.
  - ret with ras_empty=1: source 5 is used, with no pop and no underflow. The count stays 0.
  - Suppressed side effects: a lower-priority request that loses (e.g. jump&link together with branch) performs no push or pop.
- Flags: ras_empty = (count==0), ras_full = (count==RAS_DEPTH). Both are registered-derived, valid from the cycle after the update.
- Latency: npc is visible the same cycle as its inputs. pc reflects npc one clock later.

Test Plan:
- Reset, then 3 cycles with pc_wr=1 and no controls -> pc = 0, 4, 8, C. Assert reset mid-run at pc=C -> pc=0 the next cycle, RAS empty.
- pc=0x100, branch=1, imm32=0xFFFF_FFF0 -> npc=0xF4, pc=0xF4 next cycle. Same with pc_wr=0 -> pc stays 0x100.
- At pc=0x2000_0010, jump=1, link=1, imm26=0x40 -> pc=0x2000_0100, RAS top=0x2000_0014. Then jump_reg=1, ret=1, rs_val=0xDEAD -> pc=0x2000_0014, ras_empty=1.
- Five jump&link pushes with RAS_DEPTH=4, return addresses A1..A5 -> ras_full=1. Four rets -> A5, A4, A3, A2. Fifth ret with rs_val=0x303 -> pc=0x300, no underflow.
- At pc=0x40 with pc_wr=0, assert exc=1 together with branch -> pc=0x180, epc=0x40. Next, eret=1 -> pc=0x40.
- jump&link and branch asserted together -> branch target taken, RAS count unchanged.
